sh7604_irl_vector_responder: RTL

- External-side partner of the SH7604 interrupt controller.
- Collects edge-triggered interrupt requests from system peripherals and priority-encodes the winner onto the CPU's IRL_N pins.
- Answers the CPU's external-vector fetch cycles (VBUS request with level address) with a vector byte, after programmable wait states.
- Retires the serviced source and pulses an acknowledge to it. Sits between peripheral IRQ lines and the SH7604 IRL/VBUS pins.

---
 rtl/sh7604_irl_vector_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sh7604_irl_vector_responder.sv
// External interrupt responder for the SH7604. It latches edge-triggered
// peripheral requests, drives the winning level onto IRL_N, answers VBUS
// vector fetches after programmable wait states, and acknowledges the
// retired source.
module sh7604_irl_vector_responder #(
    parameter int unsigned NUM_SRC  = 8,
    parameter int unsigned WAIT_CYC = 2,
    parameter logic [7:0]  VEC_BASE = 8'h40,
    parameter logic [7:0]  VEC_SPUR = 8'h18
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CE_R,
    input  logic [NUM_SRC-1:0]     SRC_IRQ,
    input  logic [4*NUM_SRC-1:0]   SRC_LVL,
    input  logic [NUM_SRC-1:0]     SRC_MASK,
    output logic [3:0]             IRL_N,
    input  logic [3:0]             VBUS_A,
    input  logic                   VBUS_REQ,
    output logic [7:0]             VBUS_DI,
    output logic                   VBUS_WAIT,
    output logic [NUM_SRC-1:0]     PEND,
    output logic [NUM_SRC-1:0]     ACK_SRC
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_DONE
    } state_t;

    state_t               state;
    logic [NUM_SRC-1:0]   irq_prev;
    logic [NUM_SRC-1:0]   clr;
    logic [3:0]           req_lvl;
    logic [3:0]           cnt;
    logic [3:0]           sel_lvl;
    logic                 match_hit;
    logic [NUM_SRC-1:0]   match_oh;
    logic [7:0]           match_vec;

    // Highest enabled, unmasked pending level; strict compare keeps the lowest index on ties
    always_comb begin
        sel_lvl = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (PEND[i] && !SRC_MASK[i] && (SRC_LVL[4*i +: 4] != 4'd0) &&
                (SRC_LVL[4*i +: 4] > sel_lvl)) begin
                sel_lvl = SRC_LVL[4*i +: 4];
            end
        end
    end

    // Lowest-index pending, unmasked source at the level the CPU is acknowledging
    always_comb begin
        match_hit = 1'b0;
        match_oh  = '0;
        match_vec = VEC_SPUR;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!match_hit && PEND[i] && !SRC_MASK[i] && (SRC_LVL[4*i +: 4] == req_lvl)) begin
                match_hit   = 1'b1;
                match_oh[i] = 1'b1;
                match_vec   = VEC_BASE + 8'(i);
            end
        end
    end

    // Pending bit retired by this edge (only in RESP with a match)
    always_comb begin
        clr = '0;
        if (state == S_RESP) begin
            clr = match_oh;
        end
    end

    // Edge capture, IRL encoding and vector-cycle state machine
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            irq_prev  <= '0;
            PEND      <= '0;
            IRL_N     <= 4'hF;
            VBUS_DI   <= 8'h00;
            VBUS_WAIT <= 1'b0;
            ACK_SRC   <= '0;
            cnt       <= '0;
            req_lvl   <= '0;
        end else if (CE_R) begin
            irq_prev <= SRC_IRQ;
            // A new rising edge wins over a same-cycle retire
            PEND     <= (PEND & ~clr) | (SRC_IRQ & ~irq_prev);

            if ((state == S_IDLE) || (state == S_DONE)) begin
                IRL_N <= ~sel_lvl;
            end

            case (state)
                S_IDLE: begin
                    if (VBUS_REQ) begin
                        req_lvl   <= VBUS_A;
                        cnt       <= 4'(WAIT_CYC);
                        VBUS_WAIT <= 1'b1;
                        state     <= (WAIT_CYC > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (!VBUS_REQ) begin
                        VBUS_WAIT <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    VBUS_DI   <= match_vec;
                    ACK_SRC   <= match_oh;
                    VBUS_WAIT <= 1'b0;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    ACK_SRC <= '0;
                    if (!VBUS_REQ) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
